// File: rtl/ram_readout_streamer.sv
// Streams a contiguous, wrap-around block of RAM words out over a valid/ready port.
// Optional: define RAM_READOUT_HEADER_EN to send a {count, start_addr} header word first.
module ram_readout_streamer #(
  parameter int ADDR_WIDTH          = 4,
  parameter int NUMBER_OF_ADDRESSES = 1 << ADDR_WIDTH,
  parameter int DATA_WIDTH          = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  // LAUNCH is the single cycle between accepting a start and the first read;
  // it lines the first data word up at three cycles and hosts the header slot.
  typedef enum logic [1:0] {IDLE, LAUNCH, READ, DRAIN} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUMBER_OF_ADDRESSES - 1);
  localparam logic [ADDR_WIDTH:0]   Depth    = (ADDR_WIDTH + 1)'(NUMBER_OF_ADDRESSES);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   raddr_q;
  logic [ADDR_WIDTH:0]     remaining_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    inFlight_q;
  logic                    inFlightLast_q;

  logic [DATA_WIDTH-1:0]   bufData_q [2];
  logic                    bufLast_q [2];
  logic                    rdPtr_q;
  logic                    wrPtr_q;
  logic [1:0]              bufCount_q;
  logic [1:0]              bufCount_d;

  logic                    pop;
  logic                    issue;
  logic                    flush;
  logic                    push;
  logic [DATA_WIDTH-1:0]   pushData;
  logic                    pushLast;
  logic [2:0]              occupancy;
  logic [ADDR_WIDTH:0]     clampedCount;
  logic [ADDR_WIDTH-1:0]   raddrInc;

  assign busy      = busy_q;
  assign done      = done_q;
  assign raddr     = raddr_q;
  assign out_valid = (bufCount_q != 2'd0);
  assign out_data  = bufData_q[rdPtr_q];
  assign out_last  = out_valid && bufLast_q[rdPtr_q];

  // A read may only be issued if its word is guaranteed a buffer slot when it
  // returns, counting the slot freed by a pop in this same cycle.
  always_comb begin
    pop          = out_valid && out_ready;
    flush        = abort && (state_q != IDLE);
    occupancy    = {1'b0, bufCount_q} + {2'b00, inFlight_q};
    issue        = (state_q == READ) && !abort && (remaining_q != '0) &&
                   (occupancy < (3'd2 + {2'b00, pop}));
    clampedCount = (word_count > Depth) ? Depth : word_count;
    raddrInc     = (raddr_q == LastAddr) ? '0 : raddr_q + 1'b1;
    push         = inFlight_q;
    pushData     = ram_dout;
    pushLast     = inFlightLast_q;
`ifdef RAM_READOUT_HEADER_EN
    if ((state_q == LAUNCH) && !abort) begin
      push                                  = 1'b1;
      pushData                              = '0;
      pushData[ADDR_WIDTH-1:0]              = raddr_q;
      pushData[2*ADDR_WIDTH:ADDR_WIDTH]     = remaining_q;
      pushLast                              = 1'b0;
    end
`endif
    bufCount_d   = bufCount_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      raddr_q        <= '0;
      remaining_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      inFlight_q     <= 1'b0;
      inFlightLast_q <= 1'b0;
    end else begin
      done_q         <= 1'b0;
      inFlight_q     <= issue;
      inFlightLast_q <= issue && (remaining_q == (ADDR_WIDTH + 1)'(1));
      if (flush) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              if (word_count != '0) begin
                state_q     <= LAUNCH;
                raddr_q     <= start_addr;
                remaining_q <= clampedCount;
                busy_q      <= 1'b1;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          LAUNCH: begin
            state_q <= READ;
          end
          READ: begin
            if (issue) begin
              raddr_q     <= raddrInc;
              remaining_q <= remaining_q - 1'b1;
              if (remaining_q == (ADDR_WIDTH + 1)'(1)) begin
                state_q <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (pop && out_last) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Two-entry FIFO holding returned words; an abort drops its contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bufData_q[0] <= '0;
      bufData_q[1] <= '0;
      bufLast_q[0] <= 1'b0;
      bufLast_q[1] <= 1'b0;
      rdPtr_q      <= 1'b0;
      wrPtr_q      <= 1'b0;
      bufCount_q   <= 2'd0;
    end else if (flush) begin
      rdPtr_q    <= 1'b0;
      wrPtr_q    <= 1'b0;
      bufCount_q <= 2'd0;
    end else begin
      if (push) begin
        bufData_q[wrPtr_q] <= pushData;
        bufLast_q[wrPtr_q] <= pushLast;
        wrPtr_q            <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      bufCount_q <= bufCount_d;
    end
  end

endmodule

// File: tb/tb_ram_readout_streamer.sv
// Randomized self-checking bench for ram_readout_streamer against a word-list
// reference model of each readout; honours RAM_READOUT_HEADER_EN when defined.
module tb_ram_readout_streamer;

  localparam int AW = 4;
  localparam int N  = 1 << AW;
  localparam int DW = 32;
`ifdef RAM_READOUT_HEADER_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   word_count;
  logic          abort;
  logic          busy;
  logic          done;
  logic [AW-1:0] raddr;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  logic [DW-1:0] mem [N];

  int vectors;
  int miscompares;

  ram_readout_streamer #(
    .ADDR_WIDTH          (AW),
    .NUMBER_OF_ADDRESSES (N),
    .DATA_WIDTH          (DW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .raddr      (raddr),
    .ram_dout   (ram_dout),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  // Clock and a registered-output RAM read port.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ram_dout <= mem[raddr];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete readout: builds the expected word list, then drives start,
  // ready pattern, optional stall window and optional abort, checking as it goes.
  task automatic applyStimulus(input int sa, input int wc, input int readyPct,
                               input int stallAt, input int stallLen, input int abortAt);
    logic [DW-1:0] expData[$];
    logic          expLast[$];
    logic [DW-1:0] hdr;
    logic [DW-1:0] prevData;
    logic [AW-1:0] prevAddr;
    logic          prevStall;
    logic          prevLast;
    int n, total, hdrWords, j, popped, dataPopped, issued;
    int firstValid, stallLeft, maxOut, earlyDone, noisy;
    bit finished;

    n = (wc > N) ? N : wc;
    hdr = '0;
`ifdef RAM_READOUT_HEADER_EN
    if (n > 0) begin
      hdr[AW-1:0]   = AW'(sa);
      hdr[2*AW:AW]  = (AW + 1)'(n);
      expData.push_back(hdr);
      expLast.push_back(1'b0);
    end
`endif
    for (int i = 0; i < n; i++) begin
      expData.push_back(mem[(sa + i) % N]);
      expLast.push_back(i == n - 1);
    end
    total    = expData.size();
    hdrWords = total - n;

    @(negedge clk);
    start      = 1'b1;
    start_addr = AW'(sa);
    word_count = (AW + 1)'(wc);
    abort      = 1'b0;
    out_ready  = 1'b0;
    @(negedge clk);
    start = 1'b0;

    if (n == 0) begin
      checkOutput("zeroDone", done, 1);
      checkOutput("zeroBusy", busy, 0);
      checkOutput("zeroValid", out_valid, 0);
      @(negedge clk);
      checkOutput("zeroDoneOnce", done, 0);
      checkOutput("zeroBusyAfter", busy, 0);
      checkOutput("zeroValidAfter", out_valid, 0);
      return;
    end

    checkOutput("busyRise", busy, 1);
    checkOutput("raddrLoad", raddr, sa);
    prevAddr   = raddr;
    prevStall  = 1'b0;
    prevData   = '0;
    prevLast   = 1'b0;
    issued     = 0;
    popped     = 0;
    dataPopped = 0;
    firstValid = -1;
    stallLeft  = 0;
    maxOut     = 0;
    earlyDone  = 0;
    finished   = 1'b0;

    for (j = 0; j < 400; j++) begin
      if (j > 0) @(negedge clk);
      if (raddr !== prevAddr) begin
        issued++;
        checkOutput("raddrSeq", raddr, (sa + issued) % N);
        prevAddr = raddr;
      end
      if (issued - dataPopped > maxOut) maxOut = issued - dataPopped;
      if (done) earlyDone++;
      if (firstValid < 0 && out_valid) begin
        firstValid = j;
        checkOutput("firstLatency", j, LAT);
      end
      if (prevStall) begin
        checkOutput("holdValid", out_valid, 1);
        checkOutput("holdData", out_data, prevData);
        checkOutput("holdLast", out_last, prevLast);
      end
      if (abortAt >= 0 && popped == abortAt) begin
        abort     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abortValid", out_valid, 0);
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortLast", out_last, 0);
        noisy = 0;
        for (int k = 0; k < 4; k++) begin
          if (done || out_valid || busy) noisy++;
          @(negedge clk);
        end
        checkOutput("abortQuiet", noisy, 0);
        return;
      end
      if (stallLeft > 0) begin
        out_ready = 1'b0;
        stallLeft--;
      end else begin
        out_ready = ($urandom_range(0, 99) < readyPct);
      end
      if (out_valid && out_ready) begin
        if (expData.size() == 0) begin
          checkOutput("extraWord", popped, total);
        end else begin
          checkOutput("data", out_data, expData.pop_front());
          checkOutput("last", out_last, expLast.pop_front());
        end
        popped++;
        dataPopped = (popped > hdrWords) ? popped - hdrWords : 0;
        if (popped == stallAt) stallLeft = stallLen;
      end
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      prevLast  = out_last;
      if (popped == total) begin
        finished = 1'b1;
        break;
      end
    end

    checkOutput("streamComplete", popped, total);
    if (finished) begin
      checkOutput("earlyDone", earlyDone, 0);
      checkOutput("maxOutstanding", maxOut <= 2, 1);
      if (readyPct == 100 && stallAt < 0) checkOutput("throughput", j, 3 + n - 1);
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("donePulse", done, 1);
      checkOutput("doneBusy", busy, 0);
      checkOutput("doneValid", out_valid, 0);
      @(negedge clk);
      checkOutput("doneOnce", done, 0);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Busy"}, busy, 0);
    checkOutput({tag, "Done"}, done, 0);
    checkOutput({tag, "Valid"}, out_valid, 0);
    checkOutput({tag, "Last"}, out_last, 0);
    checkOutput({tag, "Raddr"}, raddr, 0);
    checkOutput({tag, "Data"}, out_data, 0);
  endtask

  initial begin
    int hdrW;
    int sa, wc, pct, ab, tot;
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    start_addr  = '0;
    word_count  = '0;
    abort       = 1'b0;
    out_ready   = 1'b0;
`ifdef RAM_READOUT_HEADER_EN
    hdrW = 1;
`else
    hdrW = 0;
`endif
    for (int i = 0; i < N; i++) mem[i] = 32'hA0 + i;

    #12;
    checkResetState("reset");
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] directed readouts");
    applyStimulus(0, 4, 100, -1, 0, -1);
    applyStimulus(14, 4, 100, -1, 0, -1);
    applyStimulus(5, 8, 100, hdrW + 2, 5, -1);
    applyStimulus(9, 0, 100, -1, 0, -1);
    applyStimulus(7, 20, 100, -1, 0, -1);
    applyStimulus(0, 8, 100, -1, 0, hdrW + 2);
    applyStimulus(3, 2, 100, -1, 0, -1);

    $display("[TB] asynchronous reset mid-stream");
    @(negedge clk);
    start      = 1'b1;
    start_addr = '0;
    word_count = 5'd8;
    out_ready  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("rstValid", out_valid, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstLast", out_last, 0);
    @(negedge clk);
    checkResetState("postRst");
    reset_n = 1'b1;
    applyStimulus(11, 6, 100, -1, 0, -1);

    $display("[TB] randomized readouts");
    for (int i = 0; i < N; i++) mem[i] = $urandom;
    for (int t = 0; t < 30; t++) begin
      sa  = $urandom_range(0, N - 1);
      wc  = $urandom_range(0, 20);
      case ($urandom_range(0, 2))
        0:       pct = 100;
        1:       pct = 70;
        default: pct = 40;
      endcase
      tot = (wc > N) ? N : wc;
      if (tot > 0) tot = tot + hdrW;
      ab  = -1;
      if (tot > 0 && $urandom_range(0, 4) == 0) ab = $urandom_range(0, tot - 1);
      applyStimulus(sa, wc, pct, -1, 0, ab);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_readout_streamer.md
Name: ram_readout_streamer

Overview:
- Reader-side sequencer for the team's inferred dual-clock RAMs; drives the RAM read address and consumes the registered read data (valid one clock after the address is sampled).
- On a start request, it streams a contiguous, wrap-around block of words out through a valid/ready interface with full backpressure support.
- Sits between a RAM read port and downstream packetizers or serializers.

Parameters:
- ADDR_WIDTH, 4, RAM address width.
- NUMBER_OF_ADDRESSES, 1<<ADDR_WIDTH, RAM depth; address wrap point.
- DATA_WIDTH, 32, RAM and stream word width.

Ports:
- clk  input  1  single clock; also drives the RAM read clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request to start a readout; sampled only in IDLE.
- start_addr  input  ADDR_WIDTH  first address; sampled with start.
- word_count  input  ADDR_WIDTH+1  words to read; sampled with start.
- abort  input  1  terminate the current readout.
- busy  output  1  readout in progress.
- done  output  1  one-cycle pulse on normal completion.
- raddr  output  ADDR_WIDTH  RAM read address (registered).
- ram_dout  input  DATA_WIDTH  RAM registered read data.
- out_data  output  DATA_WIDTH  stream data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.
- out_last  output  1  marks the final word of a readout.

Behaviour:
- Reset (reset_n low, takes effect immediately): state IDLE; busy, done, out_valid and out_last low; raddr and out_data 0; buffer and in-flight count cleared.
- States:
  - IDLE: start=1 with word_count>0 -> READ; load raddr<=start_addr, remaining<=min(word_count, NUMBER_OF_ADDRESSES), busy<=1.
  - IDLE: start=1 with word_count=0 -> done pulses next cycle; no data, busy stays low.
  - READ: issue reads until remaining=0, then -> DRAIN.
  - DRAIN: wait until the last word handshakes -> IDLE; done pulses the cycle after that handshake; busy falls in the same cycle done rises.
- Read issue: a read is issued in a cycle when state=READ, remaining>0, and (buffer occupancy + in-flight - pop_this_cycle) < 2.
  - On issue: raddr advances (NUMBER_OF_ADDRESSES-1 wraps to 0), remaining decrements, in-flight is set.
  - The word returned on ram_dout the next cycle is written into the buffer.
- Buffer: 2-entry FIFO. out_valid = buffer not empty; out_data = head entry.
  - Pop on out_valid && out_ready.
  - out_data and out_last are held stable while out_valid && !out_ready.
- Throughput: 1 word/clk while out_ready is held high. First out_valid is asserted 3 cycles after the clock edge that samples start.
- out_last is high only with the final data word of a readout.
- start while busy is ignored; start and abort together in IDLE: start wins.
- abort during READ or DRAIN: next cycle IDLE, buffer flushed, in-flight data discarded, out_valid low, busy low, no done pulse.
- word_count > NUMBER_OF_ADDRESSES is clamped, so a full-depth readout never repeats a word.

Optional Feature:
- Macro: RAM_READOUT_HEADER_EN.
- Defined:
  - The first stream word of each nonempty readout is a header: bits[ADDR_WIDTH-1:0]=start_addr, bits[2*ADDR_WIDTH:ADDR_WIDTH]=clamped word_count, upper bits 0.
  - out_last is never set on the header.
  - Data words follow with unchanged timing relative to the header slot.
  - First out_valid is asserted 1 cycle after the start edge; the data word latency stays at 3.
  - Requires DATA_WIDTH >= 2*ADDR_WIDTH+1.
- Undefined: no header; the stream carries data words only.

Test Plan:
- mem[i]=0xA0+i, start_addr=0, word_count=4, out_ready=1 -> raddr 0,1,2,3; out_data A0..A3 on 4 consecutive cycles starting at start+3; out_last with A3; done pulses the next cycle.
- ADDR_WIDTH=4, start_addr=14, word_count=4 -> raddr 14,15,0,1; out_data mem[14],mem[15],mem[0],mem[1].
- word_count=8, out_ready dropped for 5 cycles after the 2nd word -> all 8 words in order with none lost or duplicated; out_data stable while stalled; at most 2 words buffered or in flight.
- word_count=0 -> single done pulse; out_valid and busy never assert. word_count=20 with ADDR_WIDTH=4 -> exactly 16 words.
- abort after 2 of 8 words -> out_valid and busy low the next cycle, no done; a following start (start_addr=3, word_count=2) streams mem[3],mem[4] correctly.
- reset_n pulled low mid-stream (not on an edge) -> out_valid, busy and out_last go low immediately; after release, a start behaves as from power-up.
